// File: rtl/opnd_skew_fifo_bank_pkg.sv
// Shared sizing constants for the operand skew FIFO bank and the array controller.
// Latency: n/a (constants only).
// Backpressure: n/a (constants only).
package opnd_skew_fifo_bank_pkg;

    // PE array geometry, shared with the array controller
    localparam int PE_ARRAY_NUM_ROWS      = 32;
    localparam int PE_ARRAY_NUM_COLS      = 32;
    localparam int PE_ARRAY_NUM_ROWS_LOG2 = 5;
    localparam int PE_ARRAY_NUM_COLS_LOG2 = 5;

    // Operand FIFO bank defaults; one lane per PE array row (or column)
    localparam int OPND_NUM_LANES  = PE_ARRAY_NUM_ROWS;
    localparam int OPND_DWIDTH     = 8;
    localparam int OPND_DEPTH      = 64;
    localparam int OPND_DEPTH_LOG2 = 6;

    // Width of one lane slice on the SRAM row and PE edge buses
    localparam int OPND_LANE_W     = OPND_DWIDTH;

endpackage

// File: rtl/opnd_skew_fifo_bank_lane.sv
// Single operand FIFO lane: storage, pointers, count, registered head output.
// Latency: accepted pop -> o_dat/o_vld one cycle later; pushed data poppable next cycle.
// Backpressure: none; push on full without pop is dropped, pop on empty is rejected (sticky flags with OPND_SKEW_FIFO_ERR_EN).
module skew_fifo_lane
    import opnd_skew_fifo_bank_pkg::*;
#(
    parameter int DWIDTH     = OPND_DWIDTH,
    parameter int DEPTH      = OPND_DEPTH,
    parameter int DEPTH_LOG2 = OPND_DEPTH_LOG2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_stall,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DWIDTH-1:0] i_wdat,
    output logic [DWIDTH-1:0] o_dat,
    output logic              o_vld,
    output logic              o_full,
`ifdef OPND_SKEW_FIFO_ERR_EN
    output logic              o_overflow,
    output logic              o_underflow,
`endif
    output logic              o_empty
);

    localparam logic [DEPTH_LOG2:0]   L_CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   L_CNT_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] L_PTR_ONE  = DEPTH_LOG2'(1);

    logic [DWIDTH-1:0]     r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [DWIDTH-1:0]     r_dat;
    logic                  r_vld;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_adv;

    assign w_full  = (r_count == L_CNT_FULL);
    assign w_empty = (r_count == '0);
    // Pop decision uses pre-edge state, so a push into an empty lane is never bypassed
    assign w_pop   = i_pop & ~w_empty;
    // A full lane still accepts a push when the head leaves in the same cycle
    assign w_push  = i_push & (~w_full | w_pop);
    assign w_adv   = ~i_clear & ~i_stall;

    // Storage write; contents need no reset because pointers define validity
    always_ff @(posedge i_clk) begin
        if (w_adv && w_push) begin
            r_mem[r_wr_ptr] <= i_wdat;
        end
    end

    // Pointer and occupancy update; pointers wrap naturally at DEPTH
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (!i_stall) begin
            if (w_push) r_wr_ptr <= r_wr_ptr + L_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + L_PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + L_CNT_ONE;
                2'b01:   r_count <= r_count - L_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Registered head output; idle cycles drive zero to pad the diagonal skew
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dat <= '0;
            r_vld <= 1'b0;
        end else if (i_clear) begin
            r_dat <= '0;
            r_vld <= 1'b0;
        end else if (!i_stall) begin
            r_vld <= w_pop;
            r_dat <= w_pop ? r_mem[r_rd_ptr] : '0;
        end
    end

`ifdef OPND_SKEW_FIFO_ERR_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky error flags for dropped pushes and rejected pops
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (i_clear) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (!i_stall) begin
            r_overflow  <= r_overflow  | (i_push & w_full & ~w_pop);
            r_underflow <= r_underflow | (i_pop & w_empty);
        end
    end

    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;
`endif

    assign o_dat   = r_dat;
    assign o_vld   = r_vld;
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/opnd_skew_fifo_bank.sv
// Bank of per-lane operand FIFOs feeding the PE array edge with controller-driven diagonal skew.
// Latency: POPEs[i] -> DATA_out lane i / VALIDs_out[i] in 1 cycle; STALL freezes everything, CLEAR flushes.
// Backpressure: none; caller watches FULLs_out/EMPTYs_out. OPND_SKEW_FIFO_ERR_EN adds sticky OVERFLOW_out/UNDERFLOW_out.
module opnd_skew_fifo_bank
    import opnd_skew_fifo_bank_pkg::*;
#(
    parameter int NUM_LANES  = OPND_NUM_LANES,
    parameter int DWIDTH     = OPND_LANE_W,
    parameter int DEPTH      = OPND_DEPTH,
    parameter int DEPTH_LOG2 = OPND_DEPTH_LOG2
) (
    input  logic                        CLK,
    input  logic                        RSTn,
    input  logic                        CLEAR,
    input  logic                        STALL,
    input  logic [NUM_LANES*DWIDTH-1:0] SRAM_RDATA,
    input  logic [NUM_LANES-1:0]        PUSHEs,
    input  logic [NUM_LANES-1:0]        POPEs,
    output logic [NUM_LANES*DWIDTH-1:0] DATA_out,
    output logic [NUM_LANES-1:0]        VALIDs_out,
    output logic [NUM_LANES-1:0]        FULLs_out,
`ifdef OPND_SKEW_FIFO_ERR_EN
    output logic [NUM_LANES-1:0]        OVERFLOW_out,
    output logic [NUM_LANES-1:0]        UNDERFLOW_out,
`endif
    output logic [NUM_LANES-1:0]        EMPTYs_out
);

    // One independent lane per PE edge position; lane i owns bus slice [i*DWIDTH +: DWIDTH]
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        skew_fifo_lane #(
            .DWIDTH     (DWIDTH),
            .DEPTH      (DEPTH),
            .DEPTH_LOG2 (DEPTH_LOG2)
        ) u_lane (
            .i_clk       (CLK),
            .i_rst_n     (RSTn),
            .i_clear     (CLEAR),
            .i_stall     (STALL),
            .i_push      (PUSHEs[g]),
            .i_pop       (POPEs[g]),
            .i_wdat      (SRAM_RDATA[g*DWIDTH +: DWIDTH]),
            .o_dat       (DATA_out[g*DWIDTH +: DWIDTH]),
            .o_vld       (VALIDs_out[g]),
            .o_full      (FULLs_out[g]),
`ifdef OPND_SKEW_FIFO_ERR_EN
            .o_overflow  (OVERFLOW_out[g]),
            .o_underflow (UNDERFLOW_out[g]),
`endif
            .o_empty     (EMPTYs_out[g])
        );
    end

endmodule

// File: doc/opnd_skew_fifo_bank.md
Name: opnd_skew_fifo_bank

Overview:
- Bank of per-row operand FIFOs between operand SRAM read data and the systolic PE array edge.
- One SRAM row (one element per lane) is pushed into selected lanes under per-lane push enables from the array controller.
- Per-lane pop enables, staggered by the controller, drain lanes with diagonal skew into the PE array edge registers.
- Instantiated twice: once for operand 1 (row edge) and once for operand 2 (column edge).

Parameters:
- NUM_LANES, 32, number of FIFO lanes; equals PE array rows or columns.
- DWIDTH, 8, bits per operand element.
- DEPTH, 64, entries per lane; power of two, minimum 2.
- DEPTH_LOG2, 6, log2(DEPTH).

Ports:
- CLK  in  1  clock.
- RSTn  in  1  asynchronous active-low reset.
- CLEAR  in  1  synchronous flush of all lanes.
- STALL  in  1  freezes all push, pop and output state.
- SRAM_RDATA  in  NUM_LANES*DWIDTH  SRAM row; lane i = bits [i*DWIDTH +: DWIDTH].
- PUSHEs  in  NUM_LANES  per-lane push enable.
- POPEs  in  NUM_LANES  per-lane pop enable.
- DATA_out  out  NUM_LANES*DWIDTH  registered lane heads to PE edge.
- VALIDs_out  out  NUM_LANES  lane i DATA_out carries a popped element.
- FULLs_out  out  NUM_LANES  lane count == DEPTH (combinational from state).
- EMPTYs_out  out  NUM_LANES  lane count == 0 (combinational from state).

Behaviour:
- Reset (RSTn low, asynchronous): all pointers and counts = 0; DATA_out = 0; VALIDs_out = 0; EMPTYs_out = all 1s; FULLs_out = 0. Reset mid-stream discards all stored data.
- Per-lane state: wr_ptr and rd_ptr of DEPTH_LOG2 bits, wrapping naturally at DEPTH; count of DEPTH_LOG2+1 bits.
- Priority each posedge: CLEAR > STALL > normal operation.
- CLEAR: pointers, counts, DATA_out and VALIDs_out go to 0; takes effect even while STALL is high; concurrent push/pop ignored.
- STALL high (no CLEAR): no state change; DATA_out and VALIDs_out hold.
- Push, lane i: accepted when PUSHEs[i] and (not full, or full with an accepted pop the same cycle). Writes lane slice at wr_ptr, increments wr_ptr. A push on a full lane without a pop is dropped; state is unchanged.
- Pop, lane i: accepted when POPEs[i] and not empty, based on state before this edge.
  - Next cycle: DATA_out lane i = head entry, VALIDs_out[i] = 1, rd_ptr increments.
  - Latency from POPEs to DATA_out is 1 cycle.
- No accepted pop on lane i in a cycle (idle or pop-on-empty): DATA_out lane i = 0 and VALIDs_out[i] = 0 next cycle. This zero-pads the skew.
- Push and pop on an empty lane: push stored, pop rejected, no bypass. The element becomes poppable the following cycle.
- Push and pop on a full lane: both accepted, count unchanged.
- Count update: +1 for push only, -1 for pop only, unchanged otherwise.
- Lanes are fully independent. Any mix of enables across lanes is legal.

Optional Feature:
- Macro: OPND_SKEW_FIFO_ERR_EN.
- Defined: adds outputs OVERFLOW_out [NUM_LANES] and UNDERFLOW_out [NUM_LANES].
  - Bit i is a sticky set on a dropped push (full, no pop) or a rejected pop (empty), respectively.
  - Cleared by reset or CLEAR; frozen under STALL.
- Undefined: these ports and their registers are absent. Dropped and rejected operations are silent.

Decomposition:
- Shared package holds:
  - lane slicing helper constant: lane width = DWIDTH;
  - default NUM_LANES, DWIDTH, DEPTH, DEPTH_LOG2, shared with the array controller's PE_ARRAY_NUM_ROWS/COLS and _LOG2 values.
- Sub-module skew_fifo_lane: single-lane FIFO with storage, pointers, count, registered output and optional sticky flags.
- Top level is a generate loop over NUM_LANES plus bus slicing.

Test Plan:
- Reset, then idle 3 cycles -> DATA_out = 0, VALIDs_out = 0, EMPTYs_out = 0xFFFFFFFF, FULLs_out = 0.
- Push rows 0x01..0x04 in all lanes on cycles 0-3, then POPEs = 1<<i at cycle 4+i -> lane i outputs 0x01 at cycle 5+i, with zeros and VALID=0 before its first pop. Diagonal skew is visible.
- Lane 0: push 64 entries -> FULLs_out[0] = 1; 65th push alone dropped, with OVERFLOW_out[0] = 1 when the macro is on; push+pop same cycle keeps FULL and returns the oldest entry.
- Pop on empty lane 3 with a simultaneous push of 0xAA -> VALIDs_out[3] = 0 next cycle; pop one cycle later returns 0xAA.
- STALL high for 4 cycles during pops -> DATA_out holds its last value, counts unchanged, pushes and pops ignored; CLEAR asserted under STALL -> all lanes empty, outputs 0.
- Wrap-around: push and pop 200 entries through lane 7 at steady state -> output order is exact and pointers wrap with no corruption; RSTn pulsed mid-stream -> immediate empty and zero outputs.
